// File: rtl/explore_sequencer_if.sv
// Purpose : bundles the sequencer's operand-load, launch/complete and result-byte signals.
// Latency : n/a (wires only).
// Backpressure: res_ready from the byte consumer stalls the result stream.
// Ports (master = sequencer side):
//   ser_in/ser_valid          serial operand bits in (bit0->A, bit1->B, bit2->C), MSB first
//   op_a/op_b/op_c            operand registers out to the unit under exploration
//   dut_start/dut_done        launch pulse out, completion strobe in
//   dut_result                result in, valid while dut_done=1
//   res_byte/res_valid/res_ready  valid/ready result byte stream, LSB first
//   busy/timeout              status out
interface explore_sequencer_if;
  logic [2:0]  ser_in;
  logic        ser_valid;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] op_c;
  logic        dut_start;
  logic        dut_done;
  logic [31:0] dut_result;
  logic [7:0]  res_byte;
  logic        res_valid;
  logic        res_ready;
  logic        busy;
  logic        timeout;

  modport master (
    input  ser_in, ser_valid, dut_done, dut_result, res_ready,
    output op_a, op_b, op_c, dut_start, res_byte, res_valid, busy, timeout
  );

  modport slave (
    output ser_in, ser_valid, dut_done, dut_result, res_ready,
    input  op_a, op_b, op_c, dut_start, res_byte, res_valid, busy, timeout
  );
endinterface

// File: rtl/explore_sequencer.sv
// Purpose : shifts in three 32-bit operands serially, launches a unit under exploration,
//           waits for its result and streams that result out as 4 bytes, LSB first.
// Latency : 32 valid bits + 1 START + WAIT cycles + 4 byte transfers per run (ready high).
// Backpressure: res_ready low holds res_byte/res_valid stable; ser_valid gaps simply pause LOAD.
// Ports   : clk, reset (synchronous, active-high), io_bus (explore_sequencer_if.master).
// Config  : define SEQ_TIMEOUT_EN to add the WAIT watchdog (TIMEOUT_CYCLES, 2..65535);
//           without it WAIT persists until dut_done and timeout is tied low.
module explore_sequencer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  explore_sequencer_if.master        io_bus
);

  typedef enum logic [1:0] {LOAD, START, WAIT, SEND} state_t;

  state_t      r_state;
  logic [5:0]  r_cnt;
  logic [31:0] r_op_a;
  logic [31:0] r_op_b;
  logic [31:0] r_op_c;
  logic [31:0] r_result;
  logic [1:0]  r_idx;
  logic        r_dut_start;
  logic        r_res_valid;
  logic [7:0]  r_res_byte;
  logic        r_busy;

  // Byte that goes out after the current one is accepted.
  logic [1:0]  w_idx_nxt;
  logic [7:0]  w_byte_nxt;
  assign w_idx_nxt  = r_idx + 2'd1;
  assign w_byte_nxt = r_result[{w_idx_nxt, 3'b000} +: 8];

`ifdef SEQ_TIMEOUT_EN
  localparam logic [15:0] LP_TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] r_wait_cnt;
  logic        r_timeout;
  assign io_bus.timeout = r_timeout;
`else
  // Parameter only matters for the watchdog build.
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign io_bus.timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= LOAD;
      r_cnt       <= '0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_op_c      <= '0;
      r_result    <= '0;
      r_idx       <= '0;
      r_dut_start <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_byte  <= '0;
      r_busy      <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      r_wait_cnt  <= '0;
      r_timeout   <= 1'b0;
`endif
    end else begin
      case (r_state)
        LOAD: begin
          if (io_bus.ser_valid) begin
            r_op_a <= {r_op_a[30:0], io_bus.ser_in[0]};
            r_op_b <= {r_op_b[30:0], io_bus.ser_in[1]};
            r_op_c <= {r_op_c[30:0], io_bus.ser_in[2]};
            if (r_cnt == 6'd31) begin
              r_cnt       <= '0;
              r_state     <= START;
              r_dut_start <= 1'b1;
              r_busy      <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 6'd1;
            end
          end
        end
        START: begin
          r_dut_start <= 1'b0;
          r_state     <= WAIT;
`ifdef SEQ_TIMEOUT_EN
          r_wait_cnt  <= '0;
`endif
        end
        WAIT: begin
          // dut_done is checked first so a completion on the deadline cycle wins.
          if (io_bus.dut_done) begin
            r_result    <= io_bus.dut_result;
            r_res_byte  <= io_bus.dut_result[7:0];
            r_res_valid <= 1'b1;
            r_idx       <= '0;
            r_state     <= SEND;
          end
`ifdef SEQ_TIMEOUT_EN
          else if (r_wait_cnt == LP_TO_LAST) begin
            r_result    <= 32'hFFFF_FFFF;
            r_res_byte  <= 8'hFF;
            r_res_valid <= 1'b1;
            r_idx       <= '0;
            r_timeout   <= 1'b1;
            r_state     <= SEND;
          end else begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
          end
`endif
        end
        SEND: begin
          if (io_bus.res_ready) begin
            if (r_idx == 2'd3) begin
              r_res_valid <= 1'b0;
              r_busy      <= 1'b0;
              r_idx       <= '0;
              r_state     <= LOAD;
            end else begin
              r_idx      <= w_idx_nxt;
              r_res_byte <= w_byte_nxt;
            end
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end

  assign io_bus.op_a      = r_op_a;
  assign io_bus.op_b      = r_op_b;
  assign io_bus.op_c      = r_op_c;
  assign io_bus.dut_start = r_dut_start;
  assign io_bus.res_valid = r_res_valid;
  assign io_bus.res_byte  = r_res_byte;
  assign io_bus.busy      = r_busy;

endmodule

// File: tb/tb_explore_sequencer.sv
// Purpose : self-checking bench for explore_sequencer: serial load, launch, result byte stream,
//           backpressure, mid-run reset and the optional SEQ_TIMEOUT_EN watchdog.
// Latency : n/a.
// Backpressure: res_ready is stalled for configurable numbers of cycles per byte.
module tb_explore_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  explore_sequencer_if bus();

  explore_sequencer #(.TIMEOUT_CYCLES(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Everything that must read zero right after a reset edge.
  function automatic logic [107:0] rst_view();
    return {bus.busy, bus.dut_start, bus.res_valid, bus.timeout,
            bus.res_byte, bus.op_a, bus.op_b, bus.op_c};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ser_valid  = 1'b0;
    bus.ser_in     = 3'($urandom);
    bus.dut_done   = 1'b0;
    bus.dut_result = $urandom;
    bus.res_ready  = 1'b0;
  endtask

  // Shifts three words MSB first; gap<0 means random 0..3 idle cycles before each bit.
  // early counts cycles where dut_start was seen before the 32nd bit went in.
  task automatic load_word(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                           input int gap, output int early);
    early = 0;
    for (int i = 31; i >= 0; i--) begin
      int g;
      g = (gap < 0) ? int'($urandom_range(3, 0)) : gap;
      for (int s = 0; s < g; s++) begin
        bus.ser_valid = 1'b0;
        bus.ser_in    = 3'($urandom);
        tick();
        if (bus.dut_start) early++;
      end
      bus.ser_valid = 1'b1;
      bus.ser_in    = {c[i], b[i], a[i]};
      tick();
      if (i != 0 && bus.dut_start) early++;
    end
    bus.ser_valid = 1'b0;
  endtask

  // Called in START; completes after lat WAIT cycles. Junk on ignored inputs meanwhile.
  task automatic wait_done(input int lat, input logic [31:0] res, output int start_hi);
    start_hi = 0;
    bus.dut_done   = 1'($urandom);
    bus.dut_result = $urandom;
    bus.ser_valid  = 1'($urandom);
    tick();
    if (bus.dut_start) start_hi++;
    for (int k = 1; k < lat; k++) begin
      bus.dut_done   = 1'b0;
      bus.dut_result = $urandom;
      bus.ser_valid  = 1'($urandom);
      bus.ser_in     = 3'($urandom);
      tick();
      if (bus.dut_start) start_hi++;
    end
    bus.ser_valid  = 1'b0;
    bus.dut_done   = 1'b1;
    bus.dut_result = res;
    tick();
    if (bus.dut_start) start_hi++;
    bus.dut_done   = 1'b0;
    bus.dut_result = $urandom;
  endtask

  // Called in SEND; takes 4 bytes with 'stall' not-ready cycles before each.
  task automatic collect(input int stall, output logic [31:0] got, output int glitches);
    logic [7:0] held;
    got = '0;
    glitches = 0;
    for (int b = 0; b < 4; b++) begin
      held = bus.res_byte;
      if (!bus.res_valid) glitches++;
      for (int s = 0; s < stall; s++) begin
        bus.res_ready = 1'b0;
        bus.dut_done  = 1'($urandom);
        bus.ser_valid = 1'($urandom);
        tick();
        if (!bus.res_valid || bus.res_byte !== held) glitches++;
      end
      got[8*b +: 8] = bus.res_byte;
      bus.res_ready = 1'b1;
      bus.dut_done  = 1'b0;
      bus.ser_valid = 1'b0;
      tick();
    end
    bus.res_ready = 1'b0;
    bus.ser_valid = 1'b0;
    bus.dut_done  = 1'b0;
  endtask

  // One complete run against the reference: operands as shifted, bytes = result LSB first.
  task automatic full_run(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input int gap, input int lat,
                          input int stall, input logic [31:0] res);
    int early, start_hi, glitches;
    logic [31:0] got;
    load_word(a, b, c, gap, early);
    total++;
    if (early !== 0 || bus.dut_start !== 1'b1 || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL %s start_timing: early=%0d start=%b busy=%b, want early=0 start=1 busy=1",
               tag, early, bus.dut_start, bus.busy);
    end
    total++;
    if ({bus.op_a, bus.op_b, bus.op_c} !== {a, b, c}) begin
      bad++;
      $display("FAIL %s operands: got %h %h %h want %h %h %h", tag, bus.op_a, bus.op_b,
               bus.op_c, a, b, c);
    end
    wait_done(lat, res, start_hi);
    total++;
    if (start_hi !== 0) begin
      bad++;
      $display("FAIL %s start_pulse_width: extra high cycles=%0d want 0", tag, start_hi);
    end
    collect(stall, got, glitches);
    total++;
    if (got !== res || glitches !== 0) begin
      bad++;
      $display("FAIL %s bytes: got %h glitches=%0d want %h glitches=0", tag, got, glitches, res);
    end
    total++;
    if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0 ||
        {bus.op_a, bus.op_b, bus.op_c} !== {a, b, c}) begin
      bad++;
      $display("FAIL %s after_send: busy=%b vld=%b ops %h %h %h want busy=0 vld=0 ops held",
               tag, bus.busy, bus.res_valid, bus.op_a, bus.op_b, bus.op_c);
    end
  endtask

  task automatic test_reset();
    int early;
    idle_inputs();
    reset = 1'b1;
    tick();
    total++;
    if (rst_view() !== '0) begin
      bad++;
      $display("FAIL reset_initial: got %h want 0", rst_view());
    end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.ser_valid = 1'b1;
      bus.ser_in    = 3'b111;
      tick();
    end
    bus.ser_valid = 1'b1;
    reset = 1'b1;
    tick();
    total++;
    if (rst_view() !== '0) begin
      bad++;
      $display("FAIL reset_partial_load: got %h want 0", rst_view());
    end
    reset = 1'b0;
    bus.ser_valid = 1'b0;
    early = 0;
  endtask

  task automatic test_load_basic();
    full_run("basic", 32'h1234_5678, 32'h0000_FFFF, 32'h8000_0001, 0, 5, 0, 32'hCAFE_BABE);
  endtask

  task automatic test_gaps_backpressure();
    full_run("gaps", 32'h1234_5678, 32'h0000_FFFF, 32'h8000_0001, 3, 5, 7, 32'hCAFE_BABE);
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 3; r++)
      full_run("b2b", $urandom, $urandom, $urandom, 0, int'($urandom_range(4, 1)), 0, $urandom);
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++)
      full_run("rand", $urandom, $urandom, $urandom, -1, int'($urandom_range(6, 1)),
               int'($urandom_range(3, 0)), $urandom);
  endtask

  task automatic test_reset_mid();
    int early, start_hi, glitches, extra;
    logic [31:0] got;
    // During bit 17 of LOAD.
    for (int i = 0; i < 16; i++) begin
      bus.ser_valid = 1'b1;
      bus.ser_in    = 3'($urandom);
      tick();
    end
    bus.ser_valid = 1'b1;
    bus.ser_in    = 3'b111;
    reset = 1'b1;
    tick();
    total++;
    if (rst_view() !== '0) begin
      bad++;
      $display("FAIL reset_mid_load: got %h want 0", rst_view());
    end
    reset = 1'b0;
    bus.ser_valid = 1'b0;
    full_run("after_load_rst", 32'hA5A5_0F0F, 32'h0123_4567, 32'hFEDC_BA98, 0, 2, 0, 32'h0BAD_F00D);
    // Mid-WAIT, with dut_done on the reset edge.
    load_word($urandom, $urandom, $urandom, 0, early);
    tick();
    tick();
    bus.dut_done = 1'b1;
    reset = 1'b1;
    tick();
    total++;
    if (rst_view() !== '0) begin
      bad++;
      $display("FAIL reset_mid_wait: got %h want 0", rst_view());
    end
    reset = 1'b0;
    bus.dut_done = 1'b0;
    // During the second SEND byte, with ready high.
    load_word($urandom, $urandom, $urandom, 0, early);
    wait_done(3, 32'h1122_3344, start_hi);
    bus.res_ready = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    total++;
    if (rst_view() !== '0) begin
      bad++;
      $display("FAIL reset_mid_send: got %h want 0", rst_view());
    end
    reset = 1'b0;
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.res_valid) extra++;
    end
    bus.res_ready = 1'b0;
    total++;
    if (extra !== 0) begin
      bad++;
      $display("FAIL no_byte_after_reset: valid cycles=%0d want 0", extra);
    end
    full_run("after_send_rst", 32'h0000_0001, 32'h8000_0000, 32'h5555_AAAA, 1, 1, 1, 32'h7F00_80FF);
    got = '0;
    glitches = 0;
  endtask

  task automatic test_timeout();
    int early, n, viol, glitches;
    logic [31:0] got;
    load_word($urandom, $urandom, $urandom, 0, early);
    bus.dut_done = 1'b0;
    tick();
`ifdef SEQ_TIMEOUT_EN
    n = 0;
    viol = 0;
    while (!bus.res_valid && n < 100) begin
      if (bus.timeout) viol++;
      tick();
      n++;
    end
    total++;
    if (n !== 8 || viol !== 0) begin
      bad++;
      $display("FAIL timeout_fire: wait cycles=%0d early_flag=%0d want 8 and 0", n, viol);
    end
    collect(1, got, glitches);
    total++;
    if (got !== 32'hFFFF_FFFF || glitches !== 0 || bus.timeout !== 1'b1) begin
      bad++;
      $display("FAIL timeout_bytes: got %h timeout=%b want ffffffff timeout=1", got, bus.timeout);
    end
    full_run("after_timeout", $urandom, $urandom, $urandom, 0, 2, 0, 32'h0102_0304);
    total++;
    if (bus.timeout !== 1'b1) begin
      bad++;
      $display("FAIL timeout_sticky: got %b want 1", bus.timeout);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if (bus.timeout !== 1'b0) begin
      bad++;
      $display("FAIL timeout_clear: got %b want 0", bus.timeout);
    end
    // dut_done on the deadline cycle beats the watchdog.
    load_word($urandom, $urandom, $urandom, 0, early);
    tick();
    for (int i = 0; i < 7; i++) tick();
    bus.dut_done   = 1'b1;
    bus.dut_result = 32'h600D_D00D;
    tick();
    bus.dut_done = 1'b0;
    collect(0, got, glitches);
    total++;
    if (got !== 32'h600D_D00D || bus.timeout !== 1'b0) begin
      bad++;
      $display("FAIL timeout_tie: got %h timeout=%b want 600dd00d timeout=0", got, bus.timeout);
    end
`else
    viol = 0;
    for (n = 0; n < 200; n++) begin
      if (bus.busy !== 1'b1 || bus.res_valid !== 1'b0 || bus.timeout !== 1'b0) viol++;
      tick();
    end
    total++;
    if (viol !== 0) begin
      bad++;
      $display("FAIL wait_forever: bad cycles=%0d want 0", viol);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if (rst_view() !== '0) begin
      bad++;
      $display("FAIL reset_from_wait: got %h want 0", rst_view());
    end
    got = '0;
    glitches = 0;
`endif
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_load_basic();
    test_gaps_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
